bd_phase_tx: RTL and testbench

- Clocked transmitter for the two-phase bundled-data handshake used by the asynchronous pipeline stages: one req transition per token, one ack transition back.
- Accepts words from synchronous logic over valid/ready and buffers them in a small FIFO.
- Drives each word onto data_out, holds it stable for a programmable setup time, toggles req_out, then waits for the synchronised ack to match before sending the next word.
- Sits at the sync-to-async boundary, feeding the first stage of an async pipeline. That stage's latch is transparent while req == ack and closed otherwise.

---
 rtl/bd_pkg.sv | 23 ++
 rtl/bd_sync_fifo.sv | 65 ++++++
 rtl/bd_phase_tx.sv | 129 ++++++++++++
 tb/tb_bd_phase_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bd_pkg.sv
// Shared types and defaults for the two-phase bundled-data transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bd_pkg;

  localparam int DEF_DATA_WIDTH   = 4;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_CNT_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } bd_state_e;

  // One extra MSB lets full and empty be told apart when the index bits match.
  function automatic int bd_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bd_sync_fifo.sv
// Small synchronous FIFO buffering producer words ahead of the async handshake.
// Latency: a pushed word is visible at the head one clock after the push; head read is combinational.
// Backpressure: full refuses a push even when a pop happens in the same cycle.
module bd_sync_fifo
  import bd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int PW        = bd_ptr_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [PW-1:0]         count
);

  localparam int AW = PW - 1;

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count    = wptr_q - rptr_q;
  assign pop_data = mem_q[rptr_q[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Next pointers and storage write; pointers wrap naturally through the MSB.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = push_data;
      wptr_d                = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/bd_phase_tx.sv
// Sync-to-async transmitter: FIFO-buffered words sent over a two-phase req/ack bundled-data link.
// Latency: push into empty idle FIFO -> data_out next edge, req_out toggles SETUP_CYCLES edges later.
// Backpressure: in_ready = !full (and low in reset); next word waits for synchronised ack == req.
module bd_phase_tx
  import bd_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  req_out,
  input  logic                  ack_in,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  sent_count
);

  localparam int PW = bd_ptr_width(FIFO_DEPTH);
  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYCLES - 1);

  bd_state_e             state_q, state_d;
  logic [SW-1:0]         setup_cnt_q, setup_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_q, req_d;
  logic [CNT_WIDTH-1:0]  sent_q, sent_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                  ack_sync;

  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PW-1:0]         fifo_count;

  bd_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_valid),
    .push_data(in_data),
    .pop      (fifo_pop),
    .pop_data (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign ack_sync   = ack_sync_q[SYNC_STAGES-1];
  assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_in};

  assign in_ready   = rst_n && !fifo_full;
  assign data_out   = data_q;
  assign req_out    = req_q;
  assign sent_count = sent_q;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);

  // Handshake FSM: load word, hold for the bundling delay, toggle req, await matching ack.
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    data_d      = data_q;
    req_d       = req_q;
    sent_d      = sent_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        // A stray ack (ack_sync != req) parks here until it settles back.
        if (ack_sync == req_q && !fifo_empty) begin
          fifo_pop    = 1'b1;
          data_d      = fifo_rdata;
          setup_cnt_d = SETUP_LOAD;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt_q == '0) begin
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end else begin
          setup_cnt_d = setup_cnt_q - 1'b1;
        end
      end
      WAIT_ACK: begin
        if (ack_sync == req_q) begin
          sent_d = sent_q + 1'b1;
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            data_d      = fifo_rdata;
            setup_cnt_d = SETUP_LOAD;
            state_d     = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and ack synchroniser registers; reset abandons any in-flight token.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      setup_cnt_q <= '0;
      data_q      <= '0;
      req_q       <= 1'b0;
      sent_q      <= '0;
      ack_sync_q  <= '0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      data_q      <= data_d;
      req_q       <= req_d;
      sent_q      <= sent_d;
      ack_sync_q  <= ack_sync_d;
    end
  end

endmodule

// File: tb/tb_bd_phase_tx.sv
// Bench for bd_phase_tx: default instance plus a SETUP_CYCLES=3 / CNT_WIDTH=4 instance.
// Each instance is acked by a modelled async stage that mirrors req_out after 3 clocks.
// Expected words go into per-instance queues on push and are compared at each req toggle.
module tb_bd_phase_tx;
  import bd_pkg::*;

  logic       clk;
  logic       rstn     [2];
  logic [3:0] in_data  [2];
  logic       in_valid [2];
  logic       in_ready [2];
  logic [3:0] data_out [2];
  logic       req_out  [2];
  logic       ack_in   [2];
  logic       busy     [2];
  logic [15:0] sent0;
  logic [3:0]  sent1;

  logic [3:0] sb0[$];
  logic [3:0] sb1[$];
  int         checks = 0;
  int         errors = 0;
  int         tog    [2];
  logic       prev_req  [2];
  logic [3:0] prev_data [2];
  logic [2:0] line      [2];

  bd_phase_tx dut0 (
    .clk(clk), .rst_n(rstn[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .data_out(data_out[0]), .req_out(req_out[0]),
    .ack_in(ack_in[0]), .busy(busy[0]), .sent_count(sent0)
  );

  bd_phase_tx #(.SETUP_CYCLES(3), .CNT_WIDTH(4)) dut3 (
    .clk(clk), .rst_n(rstn[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .data_out(data_out[1]), .req_out(req_out[1]),
    .ack_in(ack_in[1]), .busy(busy[1]), .sent_count(sent1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sb_size(input int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  // Async stage model: ack follows req three clocks later, cleared by system reset.
  initial begin
    line[0] = '0; line[1] = '0; ack_in[0] = 1'b0; ack_in[1] = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!rstn[i]) begin
          line[i]   = '0;
          ack_in[i] = 1'b0;
        end else begin
          line[i]   = {line[i][1:0], req_out[i]};
          ack_in[i] = line[i][2];
        end
      end
    end
  end

  task automatic mon(input int i);
    logic [3:0] w;
    if (rstn[i]) begin
      if (data_out[i] != prev_data[i])
        chk("data_moved_while_req_ne_ack", 32'(req_out[i] ^ ack_in[i]), 0);
      if (req_out[i] != prev_req[i]) begin
        tog[i]++;
        chk("word_expected_at_req", 32'(sb_size(i) != 0), 1);
        if (sb_size(i) != 0) begin
          w = (i == 0) ? sb0.pop_front() : sb1.pop_front();
          chk((i == 0) ? "word0" : "word3", 32'(data_out[i]), 32'(w));
        end
      end
    end
    prev_req[i]  = req_out[i];
    prev_data[i] = data_out[i];
  endtask

  // Output monitor, sampled on the falling edge.
  initial begin
    tog[0] = 0; tog[1] = 0;
    prev_req[0] = 1'b0; prev_req[1] = 1'b0;
    prev_data[0] = '0; prev_data[1] = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) mon(i);
    end
  end

  task automatic push_word(input int i, input logic [3:0] w);
    int n;
    n = 0;
    in_data[i]  = w;
    in_valid[i] = 1'b1;
    while (!in_ready[i] && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready", 32'(in_ready[i]), 1);
    if (in_ready[i]) begin
      if (i == 0) sb0.push_back(w);
      else        sb1.push_back(w);
      tick();
    end
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while ((busy[i] || sb_size(i) != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_busy", 32'(busy[i]), 0);
    chk("drain_sb_left", 32'(sb_size(i)), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int         n;
    int         t0;
    logic [15:0] s0;
    logic [3:0]  s1;

    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 32'(in_ready[i]), 0);
      chk("rst_data_out", 32'(data_out[i]), 0);
      chk("rst_req_out", 32'(req_out[i]), 0);
      chk("rst_busy", 32'(busy[i]), 0);
    end
    chk("rst_sent0", 32'(sent0), 0);
    chk("rst_sent3", 32'(sent1), 0);
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    tick();

    // Single token with exact latency through setup and ack synchroniser.
    push_word(0, 4'hA);
    tick();
    chk("single_data", 32'(data_out[0]), 32'hA);
    chk("single_req_pre", 32'(req_out[0]), 0);
    tick();
    chk("single_req_tog", 32'(req_out[0]), 1);
    n = 0;
    do begin tick(); n++; end while (ack_in[0] != req_out[0] && n < 20);
    chk("single_ack_seen", 32'(ack_in[0]), 32'(req_out[0]));
    chk("single_sent_sync0", 32'(sent0), 0);
    tick();
    chk("single_sent_sync1", 32'(sent0), 0);
    tick();
    chk("single_sent", 32'(sent0), 1);
    chk("single_busy", 32'(busy[0]), 0);

    // Burst of six with valid held high; FIFO fills after the fifth push.
    t0 = tog[0];
    for (int k = 1; k <= 6; k++) begin
      push_word(0, 4'(k));
      if (k == 5) chk("burst_full_ready", 32'(in_ready[0]), 0);
    end
    wait_idle(0, 300);
    chk("burst_toggles", 32'(tog[0] - t0), 6);
    chk("burst_sent", 32'(sent0), 7);

    // Back-to-back: second word loaded on the edge that matches the first ack.
    push_word(0, 4'h7);
    push_word(0, 4'h8);
    s0 = sent0;
    n = 0;
    while (sent0 == s0 && n < 60) begin tick(); n++; end
    chk("b2b_sent", 32'(sent0), 32'(16'(s0 + 1'b1)));
    chk("b2b_data", 32'(data_out[0]), 32'h8);
    chk("b2b_busy", 32'(busy[0]), 1);
    chk("b2b_state", 32'(dut0.state_q), 32'(SETUP));
    wait_idle(0, 100);
    chk("b2b_sent_final", 32'(sent0), 9);

    // Reset in WAIT_ACK with three words queued.
    push_word(0, 4'h9);
    push_word(0, 4'hA);
    push_word(0, 4'hB);
    push_word(0, 4'hC);
    chk("midrst_outstanding", 32'(req_out[0] ^ ack_in[0]), 1);
    rstn[0] = 1'b0;
    sb0.delete();
    tick();
    chk("midrst_req", 32'(req_out[0]), 0);
    chk("midrst_data", 32'(data_out[0]), 0);
    chk("midrst_in_ready", 32'(in_ready[0]), 0);
    chk("midrst_sent", 32'(sent0), 0);
    rstn[0] = 1'b1;
    tick();
    chk("postrst_in_ready", 32'(in_ready[0]), 1);
    chk("postrst_busy", 32'(busy[0]), 0);

    // SETUP_CYCLES=3: data held for exactly three edges before req toggles.
    push_word(1, 4'h5);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("setup3_data", 32'(data_out[1]), 32'h5);
      chk("setup3_req_hold", 32'(req_out[1]), 0);
    end
    tick();
    chk("setup3_req_tog", 32'(req_out[1]), 1);
    chk("setup3_data_tog", 32'(data_out[1]), 32'h5);
    wait_idle(1, 100);

    // Full FIFO with a simultaneous pop: the push is refused.
    for (int k = 1; k <= 5; k++) push_word(1, 4'(k));
    chk("fullpop_ready", 32'(in_ready[1]), 0);
    in_data[1]  = 4'hF;
    in_valid[1] = 1'b1;
    s1 = sent1;
    n = 0;
    while (sent1 == s1 && n < 60) begin tick(); n++; end
    in_valid[1] = 1'b0;
    chk("fullpop_sent", 32'(sent1), 32'(4'(s1 + 1'b1)));
    chk("fullpop_count", 32'(dut3.u_fifo.count), 3);
    wait_idle(1, 200);

    // sent_count wrap at 4 bits: 17 tokens from reset -> 1.
    rstn[1] = 1'b0;
    sb1.delete();
    repeat (2) tick();
    rstn[1] = 1'b1;
    tick();
    for (int k = 0; k < 17; k++) push_word(1, 4'(k));
    wait_idle(1, 800);
    chk("wrap_sent", 32'(sent1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
